// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential fetches to a handshaked, variable-latency
// instruction memory and buffers returned words with their PC in a first-word-fall-through queue.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       instr_valid,
    output logic [31:0]                instr_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                pcplus4_out,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW:0] DEPTH_W = (OW+1)'(DEPTH);

    logic [31:0]   fpc_reg;
    logic [31:0]   rpc_reg;
    logic [OW-1:0] outst_reg;
    logic [OW-1:0] drop_reg;
    logic [OW-1:0] count_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [OW:0]   inflight;
    logic          accept;
    logic          push;
    logic          pop;
    logic [OW-1:0] outst_next;

    // Queued plus in-flight words are capped at DEPTH, so a response always has a free slot.
    assign inflight   = {1'b0, count_reg} + {1'b0, outst_reg};
    assign imem_req   = !rst && !redirect && (inflight < DEPTH_W);
    assign imem_addr  = fpc_reg;
    assign accept     = imem_req && imem_gnt;
    assign push       = imem_rvalid && (drop_reg == '0) && !redirect;
    assign pop        = instr_valid && !stall && !redirect;
    assign outst_next = outst_reg + OW'(accept) - OW'(imem_rvalid);

    assign instr_valid = (count_reg != '0);
    assign instr_out   = instr_valid ? instr_mem[rd_ptr_reg] : NOP;
    assign pc_out      = instr_valid ? pc_mem[rd_ptr_reg] : 32'h0;
    assign pcplus4_out = instr_valid ? pc_mem[rd_ptr_reg] + 32'd4 : 32'h0;
    assign occupancy   = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_reg    <= RESET_PC;
            rpc_reg    <= RESET_PC;
            outst_reg  <= '0;
            drop_reg   <= '0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            assert (!(imem_rvalid && outst_reg == '0));
            outst_reg <= outst_next;
            if (redirect) begin
                // Everything still in flight after this edge belongs to the old path.
                fpc_reg    <= redirect_pc;
                rpc_reg    <= redirect_pc;
                drop_reg   <= outst_next;
                count_reg  <= '0;
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (accept) begin
                    fpc_reg <= fpc_reg + 32'd4;
                end
                if (imem_rvalid) begin
                    if (drop_reg != '0) begin
                        drop_reg <= drop_reg - 1'b1;
                    end else begin
                        rpc_reg    <= rpc_reg + 32'd4;
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + OW'(push) - OW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= rpc_reg;
        end
    end

endmodule
